cnn_frame_scheduler: RTL and testbench

Frame-level controller in front of the `main` CNN inference pipeline. It accepts one 28x28 image from a host pixel stream with valid/ready backpressure and buffers it. It then replays the image into `main` as a gap-free 784-cycle burst, because the conv line buffers require contiguous `in_valid`. It waits for `class_valid` under a watchdog and presents the result to a consumer through a valid/ready handshake.

---
 rtl/cnn_frame_scheduler_if.sv | 50 +++++
 rtl/cnn_frame_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_cnn_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_frame_scheduler_if.sv
// ============================================================================
// Module      : cnn_frame_scheduler_if
// Description : Bundles the host pixel stream, the CNN pipeline connection
//               and the result handshake of the CNN frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnn_frame_scheduler_if #(
    parameter int ID_W = 16
);
    // host pixel stream
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    // CNN pipeline connection
    logic              cnn_in_valid;
    logic [7:0]        cnn_in_data;
    logic              cnn_flush;
    logic              cnn_class_valid;
    logic [3:0]        cnn_class_out;
    logic [31:0]       cnn_class_value;
    // result handshake
    logic              res_valid;
    logic              res_ready;
    logic [3:0]        res_class;
    logic [31:0]       res_value;
    logic [ID_W-1:0]   res_frame_id;

    // environment side: host, CNN pipeline and result consumer
    modport master (
        output s_valid, s_data, s_last,
        output cnn_class_valid, cnn_class_out, cnn_class_value,
        output res_ready,
        input  s_ready, cnn_in_valid, cnn_in_data, cnn_flush,
        input  res_valid, res_class, res_value, res_frame_id
    );

    // scheduler side
    modport slave (
        input  s_valid, s_data, s_last,
        input  cnn_class_valid, cnn_class_out, cnn_class_value,
        input  res_ready,
        output s_ready, cnn_in_valid, cnn_in_data, cnn_flush,
        output res_valid, res_class, res_value, res_frame_id
    );
endinterface

`default_nettype wire

// File: rtl/cnn_frame_scheduler.sv
// ============================================================================
// Module      : cnn_frame_scheduler
// Description : Buffers one image from the host stream, replays it to the CNN
//               as a gap-free burst, waits for the class under a watchdog and
//               hands the result to a consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_frame_scheduler #(
    parameter int IMG_PIXELS   = 784,
    parameter int TIMEOUT      = 4096,
    parameter int FLUSH_CYCLES = 16,
    parameter int ID_W         = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    cnn_frame_scheduler_if.slave  bus,
    output logic                  busy,
    output logic                  err_framing,
    output logic                  err_timeout
);

    // address width also holds IMG_PIXELS, used as the end-of-burst marker
    localparam int AW  = $clog2(IMG_PIXELS + 1);
    localparam int WCW = $clog2(TIMEOUT);
    localparam int FCW = $clog2(FLUSH_CYCLES);

    localparam logic [AW-1:0]  LAST_ADDR  = AW'(IMG_PIXELS - 1);
    localparam logic [AW-1:0]  END_ADDR   = AW'(IMG_PIXELS);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        FLUSH  = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [7:0]      mem [0:IMG_PIXELS-1];
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [WCW-1:0]  wait_cnt;
    logic [FCW-1:0]  flush_cnt;
    logic [ID_W-1:0] frame_id;

    logic            beat;
    logic            at_last;
    logic            frame_bad;
    logic            frame_done;
    logic            capture;
    logic            expire;
    logic            streaming;

    // a frame is bad when s_last and the final address do not coincide
    assign beat       = bus.s_valid & bus.s_ready;
    assign at_last    = (wr_addr == LAST_ADDR);
    assign frame_bad  = beat & (bus.s_last ^ at_last);
    assign frame_done = beat & bus.s_last & at_last;
    // a class arriving on the final wait cycle beats the watchdog
    assign capture    = (state == WAIT) & bus.cnn_class_valid;
    assign expire     = (state == WAIT) & ~bus.cnn_class_valid & (wait_cnt == WAIT_LAST);
    assign streaming  = (state == STREAM) & (rd_addr != END_ADDR);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        next_state    = state;
        bus.s_ready   = 1'b0;
        bus.cnn_flush = 1'b0;
        bus.res_valid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE, LOAD: begin
                bus.s_ready = ~rst;
                if (frame_bad) begin
                    next_state = IDLE;
                end else if (frame_done) begin
                    next_state = STREAM;
                end else if (beat) begin
                    next_state = LOAD;
                end
            end
            STREAM: begin
                if (rd_addr == END_ADDR) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (capture) begin
                    next_state = RESULT;
                end else if (expire) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                bus.cnn_flush = 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                    next_state = IDLE;
                end
            end
            RESULT: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // frame buffer write port; dropped beats never reach the buffer
    always_ff @(posedge clk) begin
        if (beat & ~frame_bad) begin
            mem[wr_addr] <= bus.s_data;
        end
    end

    // synchronous buffer read doubles as the registered CNN pixel output
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cnn_in_valid <= 1'b0;
            bus.cnn_in_data  <= 8'd0;
        end else begin
            bus.cnn_in_valid <= streaming;
            if (streaming) begin
                bus.cnn_in_data <= mem[rd_addr];
            end
        end
    end

    // addresses, watchdog, flush timer, frame id, error pulses and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr          <= '0;
            rd_addr          <= '0;
            wait_cnt         <= '0;
            flush_cnt        <= '0;
            frame_id         <= '0;
            err_framing      <= 1'b0;
            err_timeout      <= 1'b0;
            bus.res_class    <= 4'd0;
            bus.res_value    <= 32'd0;
            bus.res_frame_id <= '0;
        end else begin
            if (frame_bad | frame_done) begin
                wr_addr <= '0;
            end else if (beat) begin
                wr_addr <= wr_addr + 1'b1;
            end
            rd_addr     <= streaming ? rd_addr + 1'b1 : '0;
            wait_cnt    <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            flush_cnt   <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            err_framing <= frame_bad;
            err_timeout <= expire;
            // every wait exit consumes an id so the consumer can spot drops
            if (capture | expire) begin
                frame_id <= frame_id + 1'b1;
            end
            if (capture) begin
                bus.res_class    <= bus.cnn_class_out;
                bus.res_value    <= bus.cnn_class_value;
                bus.res_frame_id <= frame_id;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_frame_scheduler.sv
// ============================================================================
// Module      : tb_cnn_frame_scheduler
// Description : Directed self-checking bench for cnn_frame_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_frame_scheduler;

    localparam int NPIX = 784;
    localparam int TMO  = 64;
    localparam int NFL  = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err_framing;
    logic err_timeout;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    // monitor accumulators (sampled on negedge)
    int runs      = 0;
    int run_len   = 0;
    int last_run  = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int data_bad  = 0;
    int errf_cnt  = 0;
    int errt_cnt  = 0;
    int flush_cnt = 0;
    int resv_cnt  = 0;

    cnn_frame_scheduler_if #(.ID_W(16)) bus ();

    cnn_frame_scheduler #(
        .IMG_PIXELS  (NPIX),
        .TIMEOUT     (TMO),
        .FLUSH_CYCLES(NFL),
        .ID_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .err_framing(err_framing),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CNN-side observer: contiguity, ordering and event counts
    always @(negedge clk) begin
        if (bus.cnn_in_valid) begin
            if (bus.cnn_in_data !== run_len[7:0]) data_bad <= data_bad + 1;
            if (run_len == 0) begin
                runs      <= runs + 1;
                first_cyc <= cyc;
            end
            run_len  <= run_len + 1;
            last_cyc <= cyc;
        end else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
        errf_cnt  <= errf_cnt + int'(err_framing);
        errt_cnt  <= errt_cnt + int'(err_timeout);
        flush_cnt <= flush_cnt + int'(bus.cnn_flush);
        resv_cnt  <= resv_cnt + int'(bus.res_valid);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // pixel i carries i[7:0]; s_last on beat last_at (-1: never)
    task automatic send_frame(input int n, input int last_at, input bit gaps, output int t_last);
        int i;
        int tries;
        i      = 0;
        tries  = 0;
        t_last = 0;
        while (i < n) begin
            @(negedge clk);
            bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.s_data  = 8'(i);
            bus.s_last  = (i == last_at);
            if (bus.s_valid && bus.s_ready) begin
                if (i == n - 1) t_last = cyc;
                i++;
            end
            tries++;
            if (tries > 20000) begin
                check("send_stall", 64'(i), 64'(n));
                i = n;
            end
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic answer(input logic [3:0] cls, input logic [31:0] val);
        bus.cnn_class_valid = 1'b1;
        bus.cnn_class_out   = cls;
        bus.cnn_class_value = val;
        @(negedge clk);
        bus.cnn_class_valid = 1'b0;
        bus.cnn_class_out   = 4'd0;
        bus.cnn_class_value = 32'd0;
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    // stimulus and checks
    initial begin
        int  t;
        int  runs0, errf0, errt0, flush0, resv0, bad0;
        bit  stable;

        rst                 = 1'b1;
        bus.s_valid         = 1'b0;
        bus.s_data          = 8'd0;
        bus.s_last          = 1'b0;
        bus.cnn_class_valid = 1'b0;
        bus.cnn_class_out   = 4'd0;
        bus.cnn_class_value = 32'd0;
        bus.res_ready       = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("reset_ctl", {busy, bus.cnn_in_valid, bus.cnn_flush, bus.res_valid,
                            err_framing, err_timeout, bus.s_ready}, 64'd0);
        check("reset_res", {bus.res_frame_id, bus.res_class, bus.res_value}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.s_ready, 1);

        // nominal frame with random host gaps
        runs0 = runs;
        bad0  = data_bad;
        send_frame(NPIX, NPIX - 1, 1'b1, t);
        check("busy_stream", busy, 1);
        wait_until(t + 786);
        check("wait_no_valid", {bus.cnn_in_valid, busy}, 64'b01);
        @(negedge clk);
        check("burst_runs", 64'(runs - runs0), 64'd1);
        check("burst_len", 64'(last_run), 64'(NPIX));
        check("burst_first", 64'(first_cyc), 64'(t + 2));
        check("burst_last", 64'(last_cyc), 64'(t + 785));
        check("burst_data", 64'(data_bad - bad0), 64'd0);
        wait_until(t + 786 + 40);
        answer(4'd7, 32'h0000_1234);
        check("res_nominal", {bus.res_valid, bus.res_frame_id, bus.res_class, bus.res_value},
              {1'b1, 16'd0, 4'd7, 32'h0000_1234});

        // result backpressure
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(bus.res_valid === 1'b1 && bus.res_class === 4'd7 &&
                  bus.res_value === 32'h1234 && bus.res_frame_id === 16'd0 &&
                  bus.s_ready === 1'b0)) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        handshake();
        check("after_hs", {bus.res_valid, bus.s_ready, busy}, 64'b010);

        // spurious class outside WAIT
        answer(4'd2, 32'h5555);
        check("spurious", {bus.res_valid, busy}, 64'd0);

        // short frame, then long frame
        runs0 = runs;
        errf0 = errf_cnt;
        send_frame(101, 100, 1'b0, t);
        check("short_err", {err_framing, bus.s_ready, busy}, 64'b110);
        @(negedge clk);
        check("short_pulse", err_framing, 0);
        send_frame(NPIX, -1, 1'b0, t);
        check("long_err", {err_framing, bus.s_ready, busy}, 64'b110);
        repeat (3) @(negedge clk);
        check("framing_cnt", 64'(errf_cnt - errf0), 64'd2);
        check("framing_no_burst", 64'(runs - runs0), 64'd0);

        // good frame after framing errors keeps id 1; negative class value
        send_frame(NPIX, NPIX - 1, 1'b1, t);
        wait_until(t + 786 + 10);
        answer(4'd3, 32'hFFFF_FFF0);
        check("res_id1", {bus.res_valid, bus.res_frame_id, bus.res_class, bus.res_value},
              {1'b1, 16'd1, 4'd3, 32'hFFFF_FFF0});
        handshake();

        // timeout
        errt0  = errt_cnt;
        flush0 = flush_cnt;
        resv0  = resv_cnt;
        send_frame(NPIX, NPIX - 1, 1'b0, t);
        wait_until(t + 786 + TMO - 1);
        check("pre_timeout", {err_timeout, bus.cnn_flush}, 64'd0);
        @(negedge clk);
        check("timeout_edge", {err_timeout, bus.cnn_flush, busy, bus.s_ready}, 64'b1110);
        wait_until(t + 786 + TMO + NFL - 1);
        check("flush_end", {bus.cnn_flush, bus.s_ready}, 64'b10);
        @(negedge clk);
        check("flush_done", {bus.cnn_flush, bus.s_ready, busy}, 64'b010);
        repeat (2) @(negedge clk);
        check("flush_cycles", 64'(flush_cnt - flush0), 64'(NFL));
        check("timeout_pulses", 64'(errt_cnt - errt0), 64'd1);
        check("timeout_no_res", 64'(resv_cnt - resv0), 64'd0);

        // class on the final wait cycle wins; id 2 was consumed by the timeout
        errt0 = errt_cnt;
        send_frame(NPIX, NPIX - 1, 1'b1, t);
        wait_until(t + 786 + TMO - 1);
        answer(4'd9, 32'h7FFF_FFFF);
        check("race_res", {bus.res_valid, err_timeout, bus.res_frame_id, bus.res_class},
              {1'b1, 1'b0, 16'd3, 4'd9});
        handshake();
        repeat (3) @(negedge clk);
        check("race_no_timeout", 64'(errt_cnt - errt0), 64'd0);

        // reset in the middle of STREAM
        flush0 = flush_cnt;
        send_frame(NPIX, NPIX - 1, 1'b0, t);
        wait_until(t + 100);
        check("mid_stream", bus.cnn_in_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ctl", {busy, bus.cnn_in_valid, bus.cnn_flush, bus.res_valid,
                          err_framing, err_timeout, bus.s_ready}, 64'd0);
        check("rst_res", {bus.res_frame_id, bus.res_class, bus.res_value}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {bus.s_ready, busy}, 64'b10);
        repeat (2) @(negedge clk);
        check("rst_no_flush", 64'(flush_cnt - flush0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
